if_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register; upstream neighbour of the ID-stage Decoder.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/ifid_reg.sv | 38 +++
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, NOP word, opcode field
// position and default PC width.
package cpu_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority is flush > load > hold; when none of
// these applies the register takes a bubble so ID never re-executes a word.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  logic [31:0]     load_instr,
    input  logic [PC_W-1:0] load_pc_plus4,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc_plus4
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
        end else if (!(hold && valid)) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, one-outstanding imem handshake, one-entry
// response buffer and IF/ID register. Define IF_STAGE_PERF_EN for perf counters.
module if_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            ifid_valid_o,
    output logic [31:0]     ifid_instr_o,
    output logic [5:0]      ifid_opcode_o,
    output logic [PC_W-1:0] ifid_pc_plus4_o
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next, pend_pc4, buf_pc4, load_pc4;
    logic [31:0]     buf_instr, load_instr;
    logic            accept, can_load, ifid_load, buf_store;
    logic            redirect_lsb_unused;

    assign imem_req_o    = (state == S_REQ) && !rst_i;
    assign imem_addr_o   = pc;
    assign accept        = imem_req_o && imem_ready_i;
    assign can_load      = !ifid_valid_o || !stall_i || flush_i;
    assign ifid_opcode_o = ifid_instr_o[OPCODE_MSB:OPCODE_LSB];
    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ifid_load  = 1'b0;
        buf_store  = 1'b0;
        load_instr = imem_rdata_i;
        load_pc4   = pend_pc4;
        if (redirect_i) begin
            // A redirect abandons whatever is in flight; an accepted but
            // unanswered request must still have its response swallowed.
            pc_next = {redirect_pc_i[PC_W-1:2], 2'b00};
            case (state)
                S_REQ:         state_next = accept ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_next = imem_rvalid_i ? S_REQ : S_DROP;
                default:       state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        pc_next = pend_pc4;
                        if (can_load) begin
                            ifid_load  = 1'b1;
                            state_next = S_REQ;
                        end else begin
                            buf_store  = 1'b1;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    load_instr = buf_instr;
                    load_pc4   = buf_pc4;
                    if (can_load) begin
                        ifid_load  = 1'b1;
                        state_next = S_REQ;
                    end
                end
                default: begin
                    if (imem_rvalid_i) state_next = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Datapath holding registers; their contents only matter in S_WAIT/S_HOLD.
    always_ff @(posedge clk_i) begin
        if (accept) pend_pc4 <= pc + PC_W'(4);
        if (buf_store) begin
            buf_instr <= imem_rdata_i;
            buf_pc4   <= pend_pc4;
        end
    end

    ifid_reg #(.PC_W(PC_W)) u_ifid (
        .clk           (clk_i),
        .rst           (rst_i),
        .load          (ifid_load),
        .hold          (stall_i),
        .flush         (flush_i),
        .load_instr    (load_instr),
        .load_pc_plus4 (load_pc4),
        .valid         (ifid_valid_o),
        .instr         (ifid_instr_o),
        .pc_plus4      (ifid_pc_plus4_o)
    );

`ifdef IF_STAGE_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (ifid_load && !flush_i)     fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (stall_i && ifid_valid_o)   stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_i)                   flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural imem plus fetch-stream model
// predicts fetch addresses and IF/ID contents; a negedge monitor compares.
module tb_if_stage;
    import cpu_pkg::*;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [5:0]  ifid_opcode_o;
    logic [31:0] ifid_pc_plus4_o;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    if_stage #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_opcode_o   (ifid_opcode_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o)
`ifdef IF_STAGE_PERF_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          cnt;
        bit          killed;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    req_t        outq[$];
    exp_t        sbq[$];
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] last_instr = 32'h0;
    bit          exp_load_prev = 0, hold_prev = 0, flush_prev = 0;
    bit          stray_drv = 0, deliver;
    int          ready_pct = 100, fix_delay = 1, junk_pct = 0;
    int          tag = 1, accepts = 0;
    int          checks = 0, errors = 0;
    req_t        r;
    exp_t        e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model + imem responder: events sampled at the edge, new
    // responder outputs driven 1 time unit later.
    always @(posedge clk) begin
        if (rst_i) begin
            outq.delete();
            sbq.delete();
            exp_addr      = RESET_PC;
            exp_load_prev = 0;
            hold_prev     = 0;
            flush_prev    = 0;
        end else begin
            deliver = imem_rvalid_i && !stray_drv && (outq.size() > 0);
            if (imem_req_o && imem_ready_i)
                check("single_outstanding", 32'(outq.size() + sbq.size()), 32'd0);
            if (deliver) begin
                r = outq.pop_front();
                if (!r.killed && !redirect_i)
                    sbq.push_back('{instr: r.word, pc4: r.addr + 32'd4});
            end
            if (imem_req_o && imem_ready_i) begin
                check("fetch_addr", imem_addr_o, exp_addr);
                r.addr   = exp_addr;
                r.word   = {6'($urandom), 16'(tag), 10'($urandom)};
                r.cnt    = (fix_delay > 0) ? fix_delay : int'($urandom_range(3, 1));
                r.killed = 0;
                outq.push_back(r);
                tag++;
                accepts++;
                exp_addr = exp_addr + 32'd4;
            end
            if (redirect_i) begin
                foreach (outq[i]) outq[i].killed = 1;
                sbq.delete();
                exp_addr = redirect_pc_i & ~32'h3;
            end
            exp_load_prev = !redirect_i && (sbq.size() > 0) && (!ifid_valid_o || !stall_i);
            hold_prev     = !redirect_i && ifid_valid_o && stall_i;
            flush_prev    = flush_i;
        end
        #1;
        imem_ready_i = ($urandom_range(99, 0) < ready_pct);
        if (outq.size() > 0 && !rst_i) begin
            stray_drv = 0;
            if (outq[0].cnt <= 1) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = outq[0].word;
            end else begin
                outq[0].cnt   = outq[0].cnt - 1;
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = $urandom;
            end
        end else begin
            // Nothing outstanding: any rvalid here must be ignored by the DUT.
            imem_rvalid_i = rst_i || ($urandom_range(99, 0) < junk_pct);
            imem_rdata_i  = 32'hDEAD_BEEF;
            stray_drv     = imem_rvalid_i;
        end
    end

    always @(negedge clk) begin
        if (rst_i) begin
            check("rst_req", 32'(imem_req_o), 32'd0);
            check("rst_valid", 32'(ifid_valid_o), 32'd0);
            check("rst_instr", ifid_instr_o, 32'd0);
            check("rst_pc4", ifid_pc_plus4_o, 32'd0);
            last_instr = 32'h0;
        end else begin
            check("opcode_field", 32'(ifid_opcode_o), 32'(ifid_instr_o[31:26]));
            if (flush_prev) begin
                check("flush_valid", 32'(ifid_valid_o), 32'd0);
                check("flush_instr", ifid_instr_o, 32'd0);
            end else if (hold_prev) begin
                check("stall_valid", 32'(ifid_valid_o), 32'd1);
                check("stall_instr", ifid_instr_o, last_instr);
            end else if (exp_load_prev) begin
                e = sbq.pop_front();
                check("load_valid", 32'(ifid_valid_o), 32'd1);
                check("load_instr", ifid_instr_o, e.instr);
                check("load_pc4", ifid_pc_plus4_o, e.pc4);
            end else begin
                check("bubble_valid", 32'(ifid_valid_o), 32'd0);
                check("bubble_instr", ifid_instr_o, 32'd0);
            end
            last_instr = ifid_instr_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ifid_valid_o && n < 60) begin tick(); n++; end
        check("wait_ifid_valid", 32'(ifid_valid_o), 32'd1);
    endtask

    task automatic wait_outstanding();
        int n = 0;
        while (outq.size() == 0 && n < 60) begin tick(); n++; end
        check("wait_outstanding", 32'(outq.size() > 0), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_i    = 1'b1;
        flush_i       = 1'b1;
        redirect_pc_i = target;
        tick();
        redirect_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst_i = 1'b0;

        // Always-ready memory, one-cycle response latency.
        ready_pct = 100; fix_delay = 1; junk_pct = 0;
        repeat (12) tick();

        // Stall while the next word returns: it must wait in the buffer.
        wait_valid();
        stall_i = 1'b1;
        repeat (4) tick();
        stall_i = 1'b0;
        repeat (6) tick();

        // Redirect + flush with a response still in flight.
        fix_delay = 3;
        wait_outstanding();
        redirect_to(32'h40);
        repeat (10) tick();

        // Flush and stall in the same cycle.
        fix_delay = 1;
        wait_valid();
        stall_i = 1'b1;
        redirect_to(32'h100);
        stall_i = 1'b0;
        repeat (8) tick();

        // PC wrap and unaligned redirect target.
        redirect_to(32'hFFFF_FFFC);
        repeat (8) tick();
        redirect_to(32'h43);
        repeat (8) tick();

        // Reset while waiting for a response.
        fix_delay = 3;
        wait_outstanding();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (10) tick();

        // Randomized traffic.
        fix_delay = 0; ready_pct = 70; junk_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            stall_i       = ($urandom_range(3, 0) == 0);
            redirect_i    = ($urandom_range(19, 0) == 0);
            flush_i       = redirect_i;
            redirect_pc_i = $urandom;
            rst_i         = ($urandom_range(699, 0) == 0);
            tick();
        end
        stall_i = 1'b0; redirect_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
        repeat (10) tick();

        check("fetch_progress", 32'(accepts > 300), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
